// File: rtl/id_ex_pipe_pkg.sv
// rtl/id_ex_pipe_pkg.sv - opcode and control-bit constants shared by the ID/EX stage
package id_ex_pipe_pkg;

  localparam int CTRL_W = 10;
  localparam int REG_W  = 5;
  localparam int OP_W   = 6;

  localparam logic [OP_W-1:0] R_FORMAT = 6'd0;
  localparam logic [OP_W-1:0] J        = 6'd2;
  localparam logic [OP_W-1:0] BEQ      = 6'd4;
  localparam logic [OP_W-1:0] ADDIU    = 6'd9;
  localparam logic [OP_W-1:0] LW       = 6'd35;
  localparam logic [OP_W-1:0] SW       = 6'd43;

  localparam int REGDST   = 9;
  localparam int ALUOP_HI = 8;
  localparam int ALUOP_LO = 7;
  localparam int ALUSRC   = 6;
  localparam int BRANCH   = 5;
  localparam int JUMP     = 4;
  localparam int MEMREAD  = 3;
  localparam int MEMWRITE = 2;
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // Only J ignores rs; ADDIU and LW write rt rather than read it.
  function automatic logic op_uses_rs(input logic [OP_W-1:0] op);
    return op != J;
  endfunction

  function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
    return (op == R_FORMAT) || (op == SW) || (op == BEQ);
  endfunction

endpackage

// File: rtl/id_ex_pipe_hazard_detect.sv
// rtl/id_ex_pipe_hazard_detect.sv - load-use hazard detector between EX load and ID consumer
module hazard_detect
  import id_ex_pipe_pkg::*;
(
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [OP_W-1:0]  id_opcode_i,
  output logic             hz_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = op_uses_rs(id_opcode_i) && (ex_rt_i == id_rs_i);
  assign rt_match = op_uses_rt(id_opcode_i) && (ex_rt_i == id_rt_i);

  // $zero never carries a real dependency.
  assign hz_o = ex_memread_i && (ex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall, flush and event counters
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              hold,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [DATA_W-1:0] rdata2_q, rdata2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic hz;
  logic flush_ev;
  logic stall_ev;

  hazard_detect u_hazard_detect (
    .ex_memread_i (ctrl_q[MEMREAD]),
    .ex_rt_i      (rt_q),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_opcode_i  (id_opcode),
    .hz_o         (hz)
  );

  // Hold owns the upstream freeze, and a flush squashes the consumer anyway.
  assign flush_ev = flush && !hold;
  assign stall_ev = hz && !flush && !hold;
  assign stall    = stall_ev;

  always_comb begin
    ctrl_d      = ctrl_q;
    pc4_d       = pc4_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    rd_d        = rd_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!hold) begin
      ctrl_d   = (flush || hz) ? '0 : id_ctrl;
      pc4_d    = id_pc4;
      rdata1_d = id_rdata1;
      rdata2_d = id_rdata2;
      imm_d    = id_imm;
      rs_d     = id_rs;
      rt_d     = id_rt;
      rd_d     = id_rd;
    end

    if (flush_ev && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (stall_ev && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      pc4_q       <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      pc4_q       <= pc4_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_ctrl   = ctrl_q;
  assign ex_pc4    = pc4_q;
  assign ex_rdata1 = rdata1_q;
  assign ex_rdata2 = rdata2_q;
  assign ex_imm    = imm_q;
  assign ex_rs     = rs_q;
  assign ex_rt     = rt_q;
  assign ex_rd     = rd_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - randomized check of id_ex_pipe against a behavioural pipeline model
module tb_id_ex_pipe;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;
  localparam int CMAX   = (1 << CNT_W) - 1;

  localparam logic [9:0] C_RTYPE = 10'b1100000010;
  localparam logic [9:0] C_LW    = 10'b0001001011;
  localparam logic [9:0] C_ADDIU = 10'b0001000010;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        id_ctrl = '0;
  logic [5:0]        id_opcode = '0;
  logic [DATA_W-1:0] id_pc4 = '0, id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
  logic [4:0]        id_rs = '0, id_rt = '0, id_rd = '0;
  logic              flush = 1'b0, hold = 1'b0;
  logic [9:0]        ex_ctrl;
  logic [DATA_W-1:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  // Model of what EX currently holds.
  logic [9:0]        m_ctrl;
  logic [DATA_W-1:0] m_pc4, m_d1, m_d2, m_imm;
  logic [4:0]        m_rs, m_rt, m_rd;
  logic              m_dp_known;
  int                m_stalls, m_flushes;

  id_ex_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_opcode(id_opcode),
    .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush), .hold(hold),
    .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit reads_reg(input logic [5:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] r);
    bit rs_read, rt_read;
    rs_read = (op != 6'd2);
    rt_read = (op == 6'd0) || (op == 6'd43) || (op == 6'd4);
    return (rs_read && rs == r) || (rt_read && rt == r);
  endfunction

  function automatic bit model_hazard();
    if (!m_ctrl[3] || m_rt == 5'd0) return 1'b0;
    return reads_reg(id_opcode, id_rs, id_rt, m_rt);
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_pc4 = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_dp_known = 1'b1; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic check_ex(input string where);
    chk({where, ".ex_ctrl"}, 32'(ex_ctrl), 32'(m_ctrl));
    chk({where, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stalls));
    chk({where, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flushes));
    if (m_dp_known) begin
      chk({where, ".ex_pc4"}, ex_pc4, m_pc4);
      chk({where, ".ex_rdata1"}, ex_rdata1, m_d1);
      chk({where, ".ex_rdata2"}, ex_rdata2, m_d2);
      chk({where, ".ex_imm"}, ex_imm, m_imm);
      chk({where, ".ex_regs"}, {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, m_rs, m_rt, m_rd});
    end
  endtask

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic step(input string where, input logic [9:0] ctrl, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic fl, input logic hd);
    bit hz;
    id_ctrl = ctrl; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_pc4 = $urandom; id_imm = $urandom;
    flush = fl; hold = hd;
    #1;
    hz = model_hazard();
    chk({where, ".stall"}, 32'(stall), 32'(hz && !fl && !hd));
    @(posedge clk);
    if (!hd) begin
      if (fl) begin
        m_ctrl = '0; m_dp_known = 1'b0;
        if (m_flushes < CMAX) m_flushes++;
      end else if (hz) begin
        m_ctrl = '0; m_dp_known = 1'b0;
        if (m_stalls < CMAX) m_stalls++;
      end else begin
        m_ctrl = ctrl; m_pc4 = id_pc4; m_d1 = d1; m_d2 = d2; m_imm = id_imm;
        m_rs = rs; m_rt = rt; m_rd = rd; m_dp_known = 1'b1;
      end
    end
    @(negedge clk);
    check_ex(where);
  endtask

  task automatic reset_mid_cycle(input string where);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_ex(where);
    chk({where, ".stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = 6'd0; ops[1] = 6'd9; ops[2] = 6'd35; ops[3] = 6'd43; ops[4] = 6'd4; ops[5] = 6'd2;
    model_reset();

    repeat (2) @(negedge clk);
    #1 check_ex("por");
    @(negedge clk);
    rst_n = 1'b1;

    step("rtype", C_RTYPE, 6'd0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 1'b0, 1'b0);
    chk("rtype.ctrl_const", 32'(ex_ctrl), 32'(C_RTYPE));
    chk("rtype.rd_const", 32'(ex_rd), 32'd3);

    reset_mid_cycle("rst_mid");

    step("lu.lw", C_LW, 6'd35, 5'd1, 5'd8, 5'd0, 32'h10, 32'h0, 1'b0, 1'b0);
    step("lu.use", C_RTYPE, 6'd0, 5'd8, 5'd9, 5'd4, 32'h1, 32'h2, 1'b0, 1'b0);
    chk("lu.bubble", 32'(ex_ctrl), 32'd0);
    step("lu.pass", C_RTYPE, 6'd0, 5'd8, 5'd9, 5'd4, 32'h1, 32'h2, 1'b0, 1'b0);
    chk("lu.stall_cnt", 32'(stall_cnt), 32'd1);

    step("nf.lw0", C_LW, 6'd35, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("nf.r0", C_RTYPE, 6'd0, 5'd0, 5'd0, 5'd5, 32'h3, 32'h4, 1'b0, 1'b0);
    step("nf.lw8", C_LW, 6'd35, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("nf.addiu", C_ADDIU, 6'd9, 5'd2, 5'd8, 5'd0, 32'h3, 32'h4, 1'b0, 1'b0);

    step("lwlw.a", C_LW, 6'd35, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("lwlw.b", C_LW, 6'd35, 5'd8, 5'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("lwlw.b2", C_LW, 6'd35, 5'd8, 5'd9, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("lwlw.c", C_RTYPE, 6'd0, 5'd9, 5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    step("lwlw.c2", C_RTYPE, 6'd0, 5'd9, 5'd1, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0);

    reset_mid_cycle("rst_fl");
    step("fl.lw", C_LW, 6'd35, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("fl.hz", C_RTYPE, 6'd0, 5'd8, 5'd2, 5'd3, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("fl.flush_cnt", 32'(flush_cnt), 32'd1);
    chk("fl.stall_cnt", 32'(stall_cnt), 32'd0);

    step("hold.load", C_RTYPE, 6'd0, 5'd4, 5'd5, 5'd6, 32'hAA, 32'hBB, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("hold", 10'($urandom), 6'd0, 5'($urandom), 5'($urandom), 5'($urandom),
           $urandom, $urandom, 1'($urandom), 1'b1);
    chk("hold.rdata1", ex_rdata1, 32'hAA);

    for (int i = 0; i < 400; i++) begin
      logic [9:0] c;
      c = 10'($urandom);
      c[3] = ($urandom_range(0, 1) == 0);
      step("rand", c, ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    reset_mid_cycle("rst_sat");
    for (int i = 0; i < CMAX + 6; i++) begin
      step("sat.lw", C_LW, 6'd35, 5'd1, 5'd8, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0);
      step("sat.use", C_RTYPE, 6'd0, 5'd8, 5'd2, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    chk("sat.stall_cnt", 32'(stall_cnt), 32'(CMAX));

    reset_mid_cycle("rst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
